serial_adder6: RTL and testbench

- Bit-serial ripple adder. It is the addition counterpart of the 6-bit borrow-ripple subtractor.
- Operands are loaded on a start handshake. The block adds one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- The sum and carry-out are presented with a one-cycle done pulse.
- Used in the arithmetic datapath wherever area matters more than latency.

---
 rtl/serial_adder6_if.sv | 32 +++
 rtl/serial_adder6.sv | 114 +++++++++++
 tb/tb_serial_adder6.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder6_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// Carries the ovf result line only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder6_if #(
  parameter int unsigned WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, A, B,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  S, Cout, busy, done
  );

  modport slave (
    input  start, A, B,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output S, Cout, busy, done
  );
endinterface

// File: rtl/serial_adder6.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first, WIDTH+2 cycles per op.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow result output.
module serial_adder6 #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  serial_adder6_if.slave   bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic sum_bit;
  logic carry_nxt;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sum_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d = {sum_bit, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          s_d     = {sum_bit, sum_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB on this final step
          ovf_d   = c_q ^ carry_nxt;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StDone);
    bus.S    = s_q;
    bus.Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    bus.ovf  = ovf_q;
`endif
  end
endmodule

// File: tb/tb_serial_adder6.sv
// Directed self-checking bench for serial_adder6 (WIDTH=6); ovf checks only with SERIAL_ADDER_OVF_EN.
module tb_serial_adder6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  serial_adder6_if #(.WIDTH(6)) bus_if ();

  serial_adder6 #(.WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one op and waits for done; lat = edges from start edge to done.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, output int lat, output logic ok);
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    lat = 1;
    tick();
    while (bus_if.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    ok = (bus_if.done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b1;
    bus_if.A = 6'd7;
    bus_if.B = 6'd9;
    tick();
    tick();
    checks++;
    if ({bus_if.S, bus_if.Cout, bus_if.busy, bus_if.done} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got S=%0d Cout=%b busy=%b done=%b, want all 0",
               bus_if.S, bus_if.Cout, bus_if.busy, bus_if.done);
    end
    bus_if.start = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: got busy=%b, want 0", bus_if.busy);
    end
  endtask

  task automatic test_basic();
    int   done_edge = -1;
    logic early = 1'b0;
    bus_if.A = 6'd10;
    bus_if.B = 6'd5;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) begin
        checks++;
        if (bus_if.busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_busy_rise: got busy=%b, want 1", bus_if.busy);
        end
      end
      if (e == 3) begin
        checks++;
        if (bus_if.S !== 6'd0) begin
          errors++;
          $display("FAIL basic_s_hold_run: got S=%0d, want 0", bus_if.S);
        end
      end
      if (bus_if.done === 1'b1) begin
        if (done_edge >= 0) early = 1'b1;
        done_edge = e;
      end
      if (e == 6) begin
        checks++;
        if (bus_if.S !== 6'd15 || bus_if.Cout !== 1'b0) begin
          errors++;
          $display("FAIL basic_result: got S=%0d Cout=%b, want S=15 Cout=0", bus_if.S, bus_if.Cout);
        end
      end
      if (e == 7) begin
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
          errors++;
          $display("FAIL basic_busy_fall: got busy=%b done=%b, want 0 0", bus_if.busy, bus_if.done);
        end
      end
    end
    checks++;
    if (done_edge != 6 || early) begin
      errors++;
      $display("FAIL basic_latency: got done at edge %0d (multi=%b), want single pulse at 6",
               done_edge, early);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] av [3] = '{6'd63, 6'd63, 6'd0};
    logic [5:0] bv [3] = '{6'd1, 6'd63, 6'd0};
    logic [5:0] sv [3] = '{6'd0, 6'd62, 6'd0};
    logic       cv [3] = '{1'b1, 1'b1, 1'b0};
    int   lat;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], lat, ok);
      checks++;
      if (!ok || lat != 6 || bus_if.S !== sv[i] || bus_if.Cout !== cv[i]) begin
        errors++;
        $display("FAIL wrap_%0d: got ok=%b lat=%0d S=%0d Cout=%b, want lat=6 S=%0d Cout=%b",
                 i, ok, lat, bus_if.S, bus_if.Cout, sv[i], cv[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    // start held high the whole time; operand change mid-run must be ignored
    bus_if.A = 6'd10;
    bus_if.B = 6'd5;
    bus_if.start = 1'b1;
    tick();
    tick(); tick(); tick();
    bus_if.A = 6'd1;
    bus_if.B = 6'd1;
    while (bus_if.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.S !== 6'd15 || bus_if.Cout !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: got done=%b S=%0d Cout=%b, want done=1 S=15 Cout=0",
               bus_if.done, bus_if.S, bus_if.Cout);
    end
    tick();
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_not_taken: got busy=%b, want 0", bus_if.busy);
    end
    tick();
    bus_if.start = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL held_start_accepted: got busy=%b, want 1", bus_if.busy);
    end
    cyc = 0;
    while (bus_if.done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.S !== 6'd2 || bus_if.Cout !== 1'b0) begin
      errors++;
      $display("FAIL second_op: got done=%b S=%0d Cout=%b, want done=1 S=2 Cout=0",
               bus_if.done, bus_if.S, bus_if.Cout);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    int   lat;
    logic ok;
    bus_if.A = 6'd20;
    bus_if.B = 6'd20;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    bus_if.start = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.start = 1'b0;
    checks++;
    if ({bus_if.S, bus_if.Cout, bus_if.busy, bus_if.done} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: got S=%0d Cout=%b busy=%b done=%b, want all 0",
               bus_if.S, bus_if.Cout, bus_if.busy, bus_if.done);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_no_done: got activity after reset, want none");
    end
    run_op(6'd2, 6'd3, lat, ok);
    checks++;
    if (!ok || bus_if.S !== 6'd5 || bus_if.Cout !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: got ok=%b S=%0d Cout=%b, want S=5 Cout=0",
               ok, bus_if.S, bus_if.Cout);
    end
    tick();
  endtask

  task automatic test_sweep();
    int   lat;
    logic ok;
    int   tot;
    for (int a = 0; a < 64; a++) begin
      tot = a + 10;
      run_op(6'(a), 6'd10, lat, ok);
      checks++;
      if (!ok || bus_if.S !== 6'(tot % 64) || bus_if.Cout !== (tot >= 64)) begin
        errors++;
        $display("FAIL sweep_a%0d: got ok=%b S=%0d Cout=%b, want S=%0d Cout=%b",
                 a, ok, bus_if.S, bus_if.Cout, tot % 64, tot >= 64);
      end
      tick();
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [5:0] av [3] = '{6'd31, 6'd63, 6'd32};
    logic [5:0] bv [3] = '{6'd1, 6'd1, 6'd32};
    logic [5:0] sv [3] = '{6'd32, 6'd0, 6'd0};
    logic       cv [3] = '{1'b0, 1'b1, 1'b1};
    logic       ov [3] = '{1'b1, 1'b0, 1'b1};
    int   lat;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], lat, ok);
      checks++;
      if (!ok || bus_if.S !== sv[i] || bus_if.Cout !== cv[i] || bus_if.ovf !== ov[i]) begin
        errors++;
        $display("FAIL ovf_%0d: got S=%0d Cout=%b ovf=%b, want S=%0d Cout=%b ovf=%b",
                 i, bus_if.S, bus_if.Cout, bus_if.ovf, sv[i], cv[i], ov[i]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    bus_if.start = 1'b0;
    bus_if.A = '0;
    bus_if.B = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
